// File: rtl/traffic_pkg.sv
// Phase encoding and per-phase rules shared by the traffic light controller and its monitor.
// Pure declarations: no state, no latency, no flow control.
package traffic_pkg;

  localparam logic [1:0] PH_SYNC   = 2'd0;
  localparam logic [1:0] PH_RED    = 2'd1;
  localparam logic [1:0] PH_GREEN  = 2'd2;
  localparam logic [1:0] PH_YELLOW = 2'd3;

  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    case (ph)
      PH_RED:    next_phase = PH_GREEN;
      PH_GREEN:  next_phase = PH_YELLOW;
      PH_YELLOW: next_phase = PH_RED;
      default:   next_phase = PH_SYNC;
    endcase
  endfunction

  function automatic int min_phase(input logic [1:0] ph, input int red_min,
                                   input int green_min, input int yellow_min);
    case (ph)
      PH_RED:    min_phase = red_min;
      PH_GREEN:  min_phase = green_min;
      PH_YELLOW: min_phase = yellow_min;
      default:   min_phase = 0;
    endcase
  endfunction

  // Any encoding other than exactly one lamp on maps to PH_SYNC, which doubles as "illegal".
  function automatic logic [1:0] lamp_phase(input logic red, input logic yellow, input logic green);
    case ({red, yellow, green})
      3'b100:  lamp_phase = PH_RED;
      3'b001:  lamp_phase = PH_GREEN;
      3'b010:  lamp_phase = PH_YELLOW;
      default: lamp_phase = PH_SYNC;
    endcase
  endfunction

endpackage

// File: rtl/tlm_phase_timer.sv
// Saturating phase duration counter (clear / load-1 / increment); optional MAX_PHASE comparator
// under TRAFFIC_LIGHT_MONITOR_TIMEOUT_EN. One-cycle registered count, no backpressure.
module tlm_phase_timer #(
  parameter int CNT_W     = 8,
  parameter int MAX_PHASE = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load1,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
`ifdef TRAFFIC_LIGHT_MONITOR_TIMEOUT_EN
  ,
  output logic             at_max
`endif
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= CNT_W'(1);
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef TRAFFIC_LIGHT_MONITOR_TIMEOUT_EN
  // MAX_PHASE stays below the saturation value, so equality is reached once per phase occurrence.
  assign at_max = (cnt == CNT_W'(MAX_PHASE));
`else
  logic unused_max_phase;
  assign unused_max_phase = ^MAX_PHASE;
`endif

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive lamp-sequence checker: encoding, order, min/max phase duration; timeout via TRAFFIC_LIGHT_MONITOR_TIMEOUT_EN.
// All outputs registered at the edge that captures the sample; never backpressures the controller.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int RED_MIN    = 4,
  parameter int GREEN_MIN  = 4,
  parameter int YELLOW_MIN = 2,
  parameter int MAX_PHASE  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] phase_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             err_illegal,
  output logic             err_order,
  output logic             err_short,
  output logic             err_timeout,
  output logic             err_any,
  output logic             err_pulse
);

  logic [1:0] samp;
  logic [1:0] phase_nxt;
  logic       partial;
  logic       partial_nxt;
  logic       ev_illegal;
  logic       ev_order;
  logic       ev_short;
  logic       ev_timeout;
  logic       ev_any;
  logic       cyc_inc;
  logic       t_clear;
  logic       t_load1;
  logic       t_inc;
`ifdef TRAFFIC_LIGHT_MONITOR_TIMEOUT_EN
  logic       at_max;
`endif

  tlm_phase_timer #(
    .CNT_W     (CNT_W),
    .MAX_PHASE (MAX_PHASE)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (t_clear),
    .load1  (t_load1),
    .inc    (t_inc),
    .cnt    (phase_cnt)
`ifdef TRAFFIC_LIGHT_MONITOR_TIMEOUT_EN
    ,
    .at_max (at_max)
`endif
  );

  always_comb begin
    samp        = lamp_phase(red, yellow, green);
    phase_nxt   = phase;
    partial_nxt = partial;
    ev_illegal  = 1'b0;
    ev_order    = 1'b0;
    ev_short    = 1'b0;
    ev_timeout  = 1'b0;
    cyc_inc     = 1'b0;
    t_clear     = 1'b0;
    t_load1     = 1'b0;
    t_inc       = 1'b0;
    if (samp == PH_SYNC) begin
      // Illegal samples while hunting for sync are expected and not reported.
      if (phase != PH_SYNC) begin
        ev_illegal = 1'b1;
        phase_nxt  = PH_SYNC;
        t_clear    = 1'b1;
      end
    end else if (phase == PH_SYNC) begin
      phase_nxt   = samp;
      partial_nxt = 1'b1;
      t_load1     = 1'b1;
    end else if (samp == phase) begin
      t_inc = 1'b1;
`ifdef TRAFFIC_LIGHT_MONITOR_TIMEOUT_EN
      ev_timeout = at_max;
`endif
    end else begin
      ev_short    = !partial &&
                    (32'(phase_cnt) < 32'(min_phase(phase, RED_MIN, GREEN_MIN, YELLOW_MIN)));
      ev_order    = (samp != next_phase(phase));
      cyc_inc     = (phase == PH_YELLOW) && (samp == PH_RED);
      phase_nxt   = samp;
      partial_nxt = 1'b0;
      t_load1     = 1'b1;
    end
    ev_any = ev_illegal | ev_order | ev_short | ev_timeout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase       <= PH_SYNC;
      partial     <= 1'b0;
      cycle_cnt   <= '0;
      err_illegal <= 1'b0;
      err_order   <= 1'b0;
      err_short   <= 1'b0;
      err_any     <= 1'b0;
      err_pulse   <= 1'b0;
    end else begin
      phase       <= phase_nxt;
      partial     <= partial_nxt;
      cycle_cnt   <= cycle_cnt + CNT_W'(cyc_inc);
      err_illegal <= err_illegal | ev_illegal;
      err_order   <= err_order | ev_order;
      err_short   <= err_short | ev_short;
      err_any     <= err_any | ev_any;
      err_pulse   <= ev_any;
    end
  end

`ifdef TRAFFIC_LIGHT_MONITOR_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= err_timeout | ev_timeout;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

endmodule
